// File: rtl/fetch_queue_unit.sv
// Fetch stage: prioritised PC redirect, single-outstanding I-cache requests,
// and a PC-tagged instruction FIFO feeding decode.
module fetch_queue_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int INSN_SIZE = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_1000,
  parameter logic [ADDR_SIZE-1:0] EXC_VECTOR = 32'h0000_2000,
  parameter int PC_STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 is_exception,
  input  logic                 is_branch,
  input  logic                 is_jump,
  input  logic [ADDR_SIZE-1:0] pc_branch,
  input  logic [ADDR_SIZE-1:0] pc_jump,
  output logic                 icache_req_valid,
  input  logic                 icache_req_ready,
  output logic [ADDR_SIZE-1:0] icache_req_addr,
  input  logic                 icache_rsp_valid,
  input  logic [INSN_SIZE-1:0] icache_rsp_data,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [INSN_SIZE-1:0] dec_insn,
  output logic [ADDR_SIZE-1:0] dec_pc,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_SIZE-1:0] fetch_pc;
  logic [ADDR_SIZE-1:0] rsp_pc;
  logic [CW-1:0]        count;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 outstanding;
  logic                 drop;
  logic [ADDR_SIZE-1:0] mem_pc   [DEPTH];
  logic [INSN_SIZE-1:0] mem_insn [DEPTH];

  logic                 redirect;
  logic [ADDR_SIZE-1:0] target;
  logic                 accept;
  logic                 enq;
  logic                 deq;

  assign redirect = is_exception | is_branch | is_jump;

  // Redirect target, exception first, then branch, then jump
  always_comb begin
    target = pc_jump;
    if (is_exception) begin
      target = EXC_VECTOR;
    end else if (is_branch) begin
      target = pc_branch;
    end else begin
      target = pc_jump;
    end
  end

  // Space check counts the in-flight request and ignores a same-cycle dequeue
  assign icache_req_valid = !reset && !redirect && (!outstanding || icache_rsp_valid)
                            && ((count + CW'(outstanding)) < CW'(DEPTH));
  assign icache_req_addr  = fetch_pc;
  assign accept           = icache_req_valid & icache_req_ready;
  assign enq              = icache_rsp_valid & outstanding & !drop & !redirect;
  assign dec_valid        = (count != '0) && !redirect;
  assign deq              = dec_valid & dec_ready;
  assign dec_insn         = mem_insn[rd_ptr];
  assign dec_pc           = mem_pc[rd_ptr];
  assign queue_count      = count;

  // PC, request tracking and FIFO state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_insn[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= target;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      if (outstanding && icache_rsp_valid) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end else if (outstanding) begin
        // Response still in flight: keep the slot busy and discard it on arrival
        drop <= 1'b1;
      end else begin
        drop <= drop;
      end
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_SIZE'(PC_STEP);
        rsp_pc   <= fetch_pc;
      end
      if (icache_rsp_valid && outstanding) begin
        drop <= 1'b0;
      end
      if (accept) begin
        outstanding <= 1'b1;
      end else if (icache_rsp_valid) begin
        outstanding <= 1'b0;
      end
      if (enq) begin
        mem_pc[wr_ptr]   <= rsp_pc;
        mem_insn[wr_ptr] <= icache_rsp_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised successor to the single-PC fetch stage.
- Generates the fetch PC with prioritised redirects: exception, then branch, then jump, then sequential.
- Issues one-at-a-time-pipelined requests to the instruction cache over a valid/ready handshake.
- Buffers returned instructions, tagged with their PC, in a FIFO that decouples fetch from decode.
- On redirect, flushes the FIFO and discards any in-flight cache response.

Parameters:
ADDR_SIZE, 32, PC/address width
INSN_SIZE, 32, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_1000, PC after reset
EXC_VECTOR, 32'h0000_2000, redirect target on exception
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
is_exception  input  1  redirect to EXC_VECTOR (highest priority)
is_branch  input  1  redirect to pc_branch
is_jump  input  1  redirect to pc_jump (lowest redirect priority)
pc_branch  input  ADDR_SIZE  branch target
pc_jump  input  ADDR_SIZE  jump target
icache_req_valid  output  1  request valid
icache_req_ready  input  1  cache accepts request
icache_req_addr  output  ADDR_SIZE  request address (= fetch_pc)
icache_rsp_valid  input  1  response valid; arrives >= 1 cycle after acceptance, in order
icache_rsp_data  input  INSN_SIZE  returned instruction
dec_valid  output  1  head entry valid
dec_ready  input  1  decode consumes head
dec_insn  output  INSN_SIZE  head instruction
dec_pc  output  ADDR_SIZE  head PC
queue_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, asserted at any time, including mid-operation) clears all state immediately:
  - fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, outstanding=0, drop=0, rsp_pc=0.
  - Outputs: icache_req_valid=0, dec_valid=0, dec_insn=0, dec_pc=0, queue_count=0.
- redirect = is_exception | is_branch | is_jump.
  - Target selection: exception ? EXC_VECTOR : branch ? pc_branch : pc_jump.
- Request generation:
  - icache_req_valid = !redirect & (outstanding==0 | icache_rsp_valid) & (count + outstanding < DEPTH).
  - icache_req_addr = fetch_pc.
  - Accept (req_valid & req_ready): outstanding<=1, rsp_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (modulo 2^ADDR_SIZE, wraps).
  - At most one request is outstanding at any time.
- Response handling:
  - icache_rsp_valid with drop=0 and no redirect this cycle: write {rsp_pc, data} at wr_ptr and increment count. Clear outstanding unless a new request is accepted in the same cycle.
  - icache_rsp_valid with drop=1: discard the data and clear drop.
  - icache_rsp_valid with redirect the same cycle: discard the data.
  - icache_rsp_valid while outstanding==0: protocol error; ignore the data.
- Dequeue:
  - dec_valid = (count != 0) & !redirect.
  - dec_insn/dec_pc show the head entry combinationally.
  - dec_valid & dec_ready: rd_ptr++ and count--.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Redirect cycle, applied at the clock edge:
  - fetch_pc <= target; FIFO flushed (count=0, rd_ptr=wr_ptr=0); no request issued; no dequeue.
  - If outstanding=1 and no response this cycle: drop<=1 and outstanding stays 1. The stale response returns later, is discarded, and frees the slot in that cycle, so a new request may issue in that same cycle.
  - If outstanding=1 and a response arrives this cycle: the response is discarded, outstanding<=0, drop stays 0.
- Full and empty:
  - Full (count==DEPTH, or count+outstanding==DEPTH): requests stall. The space check uses registered values only; a same-cycle dequeue does not free a slot.
  - Empty: dec_valid=0.
- Throughput: with a 1-cycle cache and dec_ready=1, one instruction per cycle in steady state. First dec_valid appears 2 cycles after reset release.

Test Plan:
- Reset release, cache ready, 1-cycle response, dec_ready=1 -> requests at 0x1000, 0x1004, 0x1008 on consecutive cycles; dec_pc sequence 0x1000, 0x1004, 0x1008 with dec_insn matching the returned data.
- dec_ready=0, DEPTH=4 -> exactly 4 requests accepted; icache_req_valid stays low while queue_count=4; it reasserts the cycle after one dequeue.
- is_branch with pc_branch=0x3000 while one request is outstanding and 2 entries are queued -> queue_count=0 next cycle; stale response discarded; next request addr 0x3000; first dec_pc after the redirect is 0x3000.
- is_exception, is_branch and is_jump asserted in the same cycle -> next request addr 0x2000.
- Redirect (is_jump, pc_jump=0x4000) in the same cycle as a response -> response not enqueued, drop stays 0, next request 0x4000.
- Reset asserted mid-stream with 3 entries queued -> outputs cleared asynchronously, before the next clock edge; after release, first request 0x1000.
- Fetch PC at 0xFFFF_FFFC advancing sequentially -> next request addr wraps to 0x0000_0000.
